// File: rtl/cache_def.sv
// Shared cache definitions package.
// Holds the memory request/response structs used between the caches and the
// backing memory, the arbiter FSM state type and the requester count.
package cache_def;

    // Number of cache requesters: port 0 = instruction cache, port 1 = data cache.
    localparam int NUM_REQ = 2;

    // Request towards memory. rw=1 is a write, rw=0 a read.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rw;
        logic        valid;
    } mem_req_type;

    // Response from memory. ready marks completion of the current request.
    typedef struct packed {
        logic [31:0] data;
        logic        ready;
    } mem_data_type;

    // Arbiter FSM: IDLE = nobody owns memory, GRANT = one port owns memory.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_type;

endpackage

// File: rtl/cache_arb_slot.sv
// cache_arb_slot - single pending-request slot of the cache memory arbiter.
// Captures one request pulse, holds it until the arbiter clears it on
// completion, and flags a pulse that arrives while the slot is occupied.
//
// Ports:
//   clk_i   - clock, rising edge
//   rst_ni  - synchronous active-low reset (clears the valid flag only)
//   i_req   - request from the cache; i_req.valid is a capture pulse
//   i_clr   - owner's transaction completes this cycle; slot frees at the edge
//   o_req   - stored request; o_req.valid = slot pending (or owned)
//   o_ovf   - pulse arrived while occupied; the pulse is dropped
module cache_arb_slot
    import cache_def::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  mem_req_type i_req,
    input  logic        i_clr,
    output mem_req_type o_req,
    output logic        o_ovf
);

    logic        r_valid;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic        r_rw;

    logic        w_hold;
    logic        w_cap;

    // A slot being cleared in this cycle may accept a new request at the same
    // edge (e.g. a write-back immediately followed by its allocate).
    assign w_hold = r_valid & ~i_clr;
    assign w_cap  = i_req.valid & ~w_hold;
    assign o_ovf  = i_req.valid & w_hold;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
        end else if (w_cap) begin
            r_valid <= 1'b1;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end
    end

    // Payload only needs to be meaningful while r_valid is set.
    always_ff @(posedge clk_i) begin
        if (w_cap) begin
            r_addr <= i_req.addr;
            r_data <= i_req.data;
            r_rw   <= i_req.rw;
        end
    end

    assign o_req = '{addr: r_addr, data: r_data, rw: r_rw, valid: r_valid};

endmodule

// File: rtl/cache_mem_arb.sv
// cache_mem_arb - arbitrates the instruction cache (port 0) and the data
// cache (port 1) onto a single backing memory.
// Each port owns one pending slot; a registered owner drives the memory
// request until memory signals ready, then ownership passes directly to the
// other port if it is pending (no idle cycle), otherwise the arbiter idles.
//
// Configuration macro: CACHE_ARB_RR_EN
//   undefined : fixed priority, port 1 wins a tie, no pointer register
//   defined   : round-robin, a tie goes to the port not granted last
//
// Ports:
//   clk_i      - clock, rising edge
//   rst_ni     - synchronous active-low reset
//   req_i      - per-port request (addr, data, rw, valid pulse)
//   rsp_o      - per-port response; data mirrors memory, ready only to owner
//   mem_req_o  - request to memory, valid for the whole grant
//   mem_data_i - memory response, ready marks completion
//   busy_o     - high while in GRANT
//   err_o      - sticky: a request pulse arrived while its slot was occupied
module cache_mem_arb
    import cache_def::*;
#(
    parameter int NUM_REQ = 2   // only 2 is supported
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  mem_req_type  req_i [NUM_REQ],
    output mem_data_type rsp_o [NUM_REQ],
    output mem_req_type  mem_req_o,
    input  mem_data_type mem_data_i,
    output logic         busy_o,
    output logic         err_o
);

    arb_state_type      r_state;
    arb_state_type      w_state_nxt;
    logic               r_owner;
    logic               w_owner_nxt;
    logic               r_err;
    logic               w_err_nxt;
`ifdef CACHE_ARB_RR_EN
    logic               r_last;
    logic               w_last_nxt;
`endif

    mem_req_type        w_slot_req [NUM_REQ];
    logic [NUM_REQ-1:0] w_slot_vld;
    logic [NUM_REQ-1:0] w_pend_nxt;
    logic [NUM_REQ-1:0] w_ovf;
    logic [NUM_REQ-1:0] w_clr;
    logic               w_done;

    // Memory ready only counts while a grant is active.
    assign w_done = (r_state == GRANT) & mem_data_i.ready;

    for (genvar p = 0; p < NUM_REQ; p++) begin : g_port
        assign w_clr[p] = w_done & (int'(r_owner) == p);

        cache_arb_slot u_slot (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .i_req  (req_i[p]),
            .i_clr  (w_clr[p]),
            .o_req  (w_slot_req[p]),
            .o_ovf  (w_ovf[p])
        );

        assign w_slot_vld[p] = w_slot_req[p].valid;
        // Slot contents after this edge; only used from IDLE, where nothing
        // clears, so a plain OR with the incoming pulse is exact.
        assign w_pend_nxt[p] = w_slot_vld[p] | req_i[p].valid;

        assign rsp_o[p].data  = mem_data_i.data;
        assign rsp_o[p].ready = w_clr[p] & rst_ni;
    end

`ifdef CACHE_ARB_RR_EN
    function automatic logic f_pick(input logic [1:0] pend, input logic last);
        if (pend[0] & pend[1]) begin
            return ~last;
        end
        return pend[1];
    endfunction
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_err_nxt   = r_err | (|w_ovf);
`ifdef CACHE_ARB_RR_EN
        w_last_nxt  = r_last;
`endif
        case (r_state)
            IDLE: begin
                if (|w_pend_nxt) begin
                    w_state_nxt = GRANT;
`ifdef CACHE_ARB_RR_EN
                    w_owner_nxt = f_pick(w_pend_nxt, r_last);
                    w_last_nxt  = w_owner_nxt;
`else
                    w_owner_nxt = w_pend_nxt[1];
`endif
                end
            end
            GRANT: begin
                if (mem_data_i.ready) begin
                    // Only the other port's registered slot is considered:
                    // a request captured in this cycle waits one IDLE cycle.
                    if (w_slot_vld[~r_owner]) begin
                        w_owner_nxt = ~r_owner;
`ifdef CACHE_ARB_RR_EN
                        w_last_nxt  = ~r_owner;
`endif
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_owner <= 1'b0;
            r_err   <= 1'b0;
`ifdef CACHE_ARB_RR_EN
            r_last  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_err   <= w_err_nxt;
`ifdef CACHE_ARB_RR_EN
            r_last  <= w_last_nxt;
`endif
        end
    end

    // Outputs are forced quiet while reset is asserted so an abandoned
    // transaction never shows up in the reset cycle itself.
    always_comb begin
        mem_req_o = '0;
        if ((r_state == GRANT) && rst_ni) begin
            mem_req_o       = w_slot_req[r_owner];
            mem_req_o.valid = 1'b1;
        end
    end

    assign busy_o = (r_state == GRANT) & rst_ni;
    assign err_o  = r_err & rst_ni;

endmodule

// File: doc/cache_mem_arb.md
CACHE_MEM_ARB -- requirements
Module: cache_mem_arb

Interface
REQ-001 Parameter: NUM_REQ, 2, number of cache requesters; port 0 = instruction cache, port 1 = data cache; only 2 is supported.
REQ-002 Port: clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_ni  input  1  reset; synchronous, active-low.
REQ-004 Port: req_i  input  NUM_REQ x mem_req_type  per-requester memory request (addr, data, rw, valid); valid may be a one-cycle pulse.
REQ-005 Port: rsp_o  output  NUM_REQ x mem_data_type  per-requester response (data, ready).
REQ-006 Port: mem_req_o  output  mem_req_type  request to the single backing memory.
REQ-007 Port: mem_data_i  input  mem_data_type  memory response; ready marks completion.
REQ-008 Port: busy_o  output  1  high while a transaction is outstanding to memory.
REQ-009 Port: err_o  output  1  sticky protocol-violation flag.

Function
REQ-010 Each port shall own one pending slot (valid, addr, data, rw); a request with req_i[p].valid=1 in cycle N is captured at the end of cycle N and is pending from cycle N+1.
REQ-011 FSM states: IDLE (no grant) and GRANT (one port owns memory); the owner index shall be registered.
REQ-012 IDLE -> GRANT when at least one slot is pending; the winner is chosen per REQ-019; mem_req_o is driven from the winner's slot, with valid=1, from the first GRANT cycle.
REQ-013 In GRANT, mem_req_o shall hold addr/data/rw/valid stable until the cycle in which mem_data_i.ready=1.
REQ-014 In the cycle with mem_data_i.ready=1, rsp_o[owner].ready=1 and rsp_o[owner].data=mem_data_i.data (combinational); the owner's slot shall clear at that edge.
REQ-015 On completion: if the other slot is pending, stay in GRANT with the new owner and drive mem_req_o.valid=1 in the next cycle (zero idle cycles); otherwise go to IDLE.
REQ-016 A request captured in the completion cycle (write-back followed by allocate) is pending from the next cycle and is granted at the earliest one cycle after that.
REQ-017 rsp_o[p].ready shall be 0 for every non-owner port and in IDLE; rsp_o[p].data shall carry mem_data_i.data on all ports.
REQ-018 mem_data_i.ready in IDLE shall be ignored.
REQ-019 Fixed priority (default): port 1 wins when both ports are pending.
REQ-020 A req_i[p].valid pulse while port p's slot is pending or owned shall be dropped and shall set err_o; err_o clears only on reset.
REQ-021 busy_o = 1 exactly while in GRANT.

Reset
REQ-022 While rst_ni=0 at a clock edge: state IDLE, all slots invalid, owner 0, err_o 0, and the round-robin pointer (if present) pointing at port 0 as last granted.
REQ-023 Outputs during and after reset: mem_req_o.valid 0, all rsp_o ready 0, busy_o 0; a reset asserted mid-transaction abandons the transaction, and late memory responses after it are ignored (REQ-018).

Configuration
REQ-024 Macro CACHE_ARB_RR_EN: when defined, the arbiter shall use round-robin; on a tie, the port not granted last wins, and the pointer updates on every grant.
REQ-025 Without CACHE_ARB_RR_EN: fixed priority per REQ-019, and no pointer register shall exist.

Structure
REQ-026 mem_req_type and mem_data_type shall be reused from the shared cache_def package; cache_def shall also hold arb_state_type (IDLE, GRANT) and the constant NUM_REQ=2.
REQ-027 One sub-module, cache_arb_slot, shall implement a single pending slot (capture, clear, overflow detect) and be instantiated once per port.

Verification
REQ-028 Single read: port 0 pulses addr=0x0000_0100, rw=0 at cycle 1; memory returns ready with data 0xDEAD_BEEF at cycle 5 -> mem_req_o.valid is high in cycles 2-5; rsp_o[0].ready=1 with data 0xDEAD_BEEF only in cycle 5; IDLE in cycle 6.
REQ-029 Simultaneous pulses from ports 0 and 1 at cycle 1 (no macro) -> port 1 is granted in cycle 2; port 0 is granted in the cycle after port 1's ready, with no idle gap.
REQ-030 CACHE_ARB_RR_EN with both ports pulsing repeatedly on every completion -> grants alternate 1,0,1,0.
REQ-031 Port 1 write-back (rw=1, addr 0x0000_2040) followed by an allocate pulse in its ready cycle -> allocate (rw=0) is granted two cycles after write-back ready; err_o stays 0.
REQ-032 Port 0 pulses twice before its response -> second pulse dropped, err_o=1 and sticky; the first transaction completes normally.
REQ-033 rst_ni=0 during GRANT, memory ready arrives after reset release -> mem_req_o.valid=0 and all rsp_o ready=0, busy_o=0, err_o=0.
